// File: rtl/err_inj_sched.sv
// Error-injection scheduler: runs one programmed campaign of timed pulses
// (delay, width, gap, count) toward the local error-control splitter.
module err_inj_sched #(
   parameter int unsigned INW  = 1,
   parameter int unsigned DLYW = 16,
   parameter int unsigned CNTW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [INW-1:0]  cfg_target,
   input  logic [DLYW-1:0] cfg_delay,
   input  logic [DLYW-1:0] cfg_width,
   input  logic [DLYW-1:0] cfg_gap,
   input  logic [CNTW-1:0] cfg_count,
   input  logic            abort,
   output logic            err_en,
   output logic [INW-1:0]  err_ctrl,
   output logic            busy,
   output logic            done,
   output logic            aborted,
   output logic [CNTW-1:0] inj_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DELAY,
      S_INJECT,
      S_GAP,
      S_DONE
   } state_t;

   state_t          state;
   logic [DLYW-1:0] cnt;
   logic [DLYW-1:0] w_lat;
   logic [DLYW-1:0] g_lat;
   logic [CNTW-1:0] n_lat;
   logic [DLYW-1:0] w_m1_in;
   logic [DLYW-1:0] g_m1_in;

   // Width and gap are stored pre-decremented so the counter ends each phase at zero.
   always_comb begin
      w_m1_in = (cfg_width == '0) ? '0 : cfg_width - 1'b1;
      g_m1_in = (cfg_gap   == '0) ? '0 : cfg_gap   - 1'b1;
   end

   assign cfg_ready = (state == S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         w_lat     <= '0;
         g_lat     <= '0;
         n_lat     <= '0;
         err_en    <= 1'b0;
         err_ctrl  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         inj_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (cfg_valid) begin
                  err_ctrl  <= cfg_target;
                  w_lat     <= w_m1_in;
                  g_lat     <= g_m1_in;
                  n_lat     <= cfg_count;
                  inj_count <= '0;
                  aborted   <= 1'b0;
                  busy      <= 1'b1;
                  if (cfg_count == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else if (cfg_delay == '0) begin
                     // Zero delay: first pulse starts in the cycle right after accept.
                     state     <= S_INJECT;
                     err_en    <= 1'b1;
                     inj_count <= CNTW'(1);
                     cnt       <= w_m1_in;
                  end else begin
                     state <= S_DELAY;
                     cnt   <= cfg_delay - 1'b1;
                  end
               end
            end

            S_DELAY, S_GAP: begin
               if (abort) begin
                  state   <= S_DONE;
                  err_en  <= 1'b0;
                  done    <= 1'b1;
                  aborted <= 1'b1;
               end else if (cnt == '0) begin
                  state  <= S_INJECT;
                  err_en <= 1'b1;
                  cnt    <= w_lat;
                  if (inj_count != '1)
                     inj_count <= inj_count + CNTW'(1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_INJECT: begin
               if (abort) begin
                  state   <= S_DONE;
                  err_en  <= 1'b0;
                  done    <= 1'b1;
                  aborted <= 1'b1;
               end else if (cnt == '0) begin
                  err_en <= 1'b0;
                  if (inj_count == n_lat) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_GAP;
                     cnt   <= g_lat;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state  <= S_IDLE;
               err_en <= 1'b0;
               done   <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/err_inj_sched.md
# err_inj_sched

Error-injection scheduler that sequences the local error-control splitter. It accepts one programmed injection campaign: target index, start delay, pulse width, inter-pulse gap and pulse count. It then drives `err_en` and `err_ctrl`, so the downstream one-hot decoder asserts exactly one local error line with the requested timing. It sits between the host/config logic and the splitter, inside the error-injector top level.

## Interface
- `INW`, 1: width of the target index (`err_ctrl`); matches the splitter's `INW`.
- `DLYW`, 16: width of the delay, width and gap counters.
- `CNTW`, 8: width of the pulse count and issued-pulse counter.

- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: a campaign is offered on the `cfg_*` buses.
- `cfg_ready` out 1: the scheduler is idle and accepts a campaign.
- `cfg_target` in INW: local error index to inject.
- `cfg_delay` in DLYW: cycles from accept to the first pulse.
- `cfg_width` in DLYW: pulse width in cycles; 0 is treated as 1.
- `cfg_gap` in DLYW: low cycles between pulses; 0 is treated as 1.
- `cfg_count` in CNTW: number of pulses; 0 means none.
- `abort` in 1: terminates the active campaign.
- `err_en` out 1: injection enable, goes to the splitter.
- `err_ctrl` out INW: target index, goes to the splitter.
- `busy` out 1: a campaign is active (any state other than IDLE).
- `done` out 1: single-cycle pulse at campaign end.
- `aborted` out 1: sticky flag set when the last campaign ended by `abort`.
- `inj_count` out CNTW: pulses issued in the current or last campaign.

## Operation
- Outputs:
  - All outputs except `cfg_ready` are registered.
  - `cfg_ready` = (state == IDLE).
- States and behaviour:
  - **IDLE**: `cfg_ready`=1. A transfer occurs when `cfg_valid && cfg_ready` is sampled at a clock edge (the accept edge). On accept:
    - latch all `cfg_*`;
    - set `err_ctrl` = `cfg_target`;
    - clear `inj_count` and `aborted`;
    - load the counter with `cfg_delay`;
    - go to DELAY, or to DONE if `cfg_count`==0.
  - **DELAY**: the counter decrements each cycle. When the counter reaches 0, the next edge enters INJECT.
  - **INJECT**: `err_en`=1 for max(W,1) cycles. On the first cycle of each pulse, `inj_count` increments by 1. On the pulse's last cycle:
    - if pulses issued == `cfg_count`, go to DONE;
    - otherwise go to GAP for max(G,1) cycles, then return to INJECT.
  - **DONE**: `done`=1 for exactly one cycle, `err_en`=0. Then go to IDLE.
- `err_ctrl` holds the latched target from accept until the next accept; it does not change mid-campaign.
- `cfg_*` changes after accept have no effect.
- `abort` (sampled in DELAY, INJECT or GAP):
  - next cycle: state DONE, `err_en`=0, `aborted`=1;
  - `inj_count` keeps the number of pulses already started;
  - `abort` in IDLE or DONE is ignored.
- `abort` wins over pulse-end and gap-end transitions in the same cycle.
- `inj_count` saturates at 2^CNTW-1; it cannot exceed `cfg_count` anyway.
- Counter arithmetic is unsigned DLYW bits with no wrap: it is reloaded before reaching zero underflow.
- Reset (asynchronous, at any point including mid-pulse):
  - state IDLE;
  - `err_en`=0, `err_ctrl`=0, `busy`=0, `done`=0, `aborted`=0, `inj_count`=0;
  - `cfg_ready`=1 once `rst` deasserts.
  - `err_en` must fall asynchronously with `rst`.

## Timing
Cycle 0 is the cycle in which the accept is sampled.
- `busy` rises in cycle 1.
- First `err_en` high cycle: cycle 1+D.
- Pulse k (k=0..N-1) occupies cycles 1+D+k·(W'+G') .. D+k·(W'+G')+W', where W'=max(W,1) and G'=max(G,1).
- `done`: the cycle after the last `err_en` high cycle.
- `busy`:
  - high from cycle 1 through the DONE cycle;
  - `cfg_ready` returns to 1 the cycle after `done`.
- N=0: `done` in cycle 1, no `err_en`, `inj_count`=0.
- `abort` sampled in cycle t: `err_en`=0 and `done`=1 in cycle t+1, IDLE in cycle t+2.
- Minimum campaign-to-campaign spacing: a new accept is possible in the cycle after `done`.

## Test plan
- D=2, W=3, G=1, N=2, target=1:
  - `err_en` high in cycles 3-5 and 7-9, `err_ctrl`=1 throughout;
  - `done` in cycle 10, `inj_count`=2, `cfg_ready` in cycle 11.
- D=0, W=0, G=0, N=3:
  - `err_en` pulses in cycles 1, 3, 5;
  - `done` in cycle 6, `inj_count`=3.
- N=0, D=5: `done` in cycle 1, `err_en` never asserts, `inj_count`=0.
- D=0, W=10, N=4, `abort` asserted in cycle 4:
  - `err_en` low from cycle 5;
  - `done` in cycle 5, `aborted`=1, `inj_count`=1.
- `rst` asserted mid-pulse (cycle 2 of a W=5 campaign):
  - `err_en` drops immediately; all outputs at reset values;
  - after release, a new campaign with target=0, D=0, W=1, N=1 gives `err_en` in cycle 1 and `done` in cycle 2.
- `cfg_valid` held high with changing `cfg_*` during a campaign:
  - no re-accept while busy;
  - the latched `cfg_target` and timing are unchanged;
  - the next accept occurs in the cycle after `done`.
